// File: rtl/program_sequencer.sv
// Run-control FSM for the 8-bit core: start/done handshake, core clear, PC load and PC gating.
// Optional run watchdog enabled by defining PROGRAM_SEQUENCER_WATCHDOG_EN.
module program_sequencer #(
    parameter int unsigned PC_W           = 32,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned PROG0_BASE     = 0,
    parameter int unsigned PROG1_BASE     = 256,
    parameter int unsigned PROG2_BASE     = 512,
    parameter int unsigned PROG3_BASE     = 768,
    parameter int unsigned TIMEOUT_CYCLES = 4095
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       prog_sel,
    input  logic             halt,
    output logic             pc_en,
    output logic             pc_load,
    output logic [PC_W-1:0]  pc_load_value,
    output logic             core_clear,
    output logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] cycle_count,
    output logic             timeout
);

`ifdef PROGRAM_SEQUENCER_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_HOLD,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             start_q;
    logic [PC_W-1:0]  base_q, base_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             start_rise;
    logic             wd_hit;

    function automatic logic [PC_W-1:0] base_of(input logic [1:0] sel);
        case (sel)
            2'd0:    base_of = PC_W'(PROG0_BASE);
            2'd1:    base_of = PC_W'(PROG1_BASE);
            2'd2:    base_of = PC_W'(PROG2_BASE);
            default: base_of = PC_W'(PROG3_BASE);
        endcase
    endfunction

    assign start_rise = start && !start_q;
    // Watchdog fires only when the current cycle is not already a normal halt.
    assign wd_hit     = WD_EN && (cnt_q == TIMEOUT_CNT) && !halt;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            start_q   <= 1'b0;
            base_q    <= PC_W'(PROG0_BASE);
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start;
            base_q    <= base_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic; a start rise restarts from CLEAR in every state but CLEAR
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_rise) begin
                    base_d  = base_of(prog_sel);
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                cnt_d     = '0;
                timeout_d = 1'b0;
                state_d   = S_HOLD;
            end
            S_HOLD: begin
                if (start_rise) begin
                    base_d  = base_of(prog_sel);
                    state_d = S_CLEAR;
                end else if (!start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (start_rise) begin
                    base_d  = base_of(prog_sel);
                    state_d = S_CLEAR;
                end else if (wd_hit) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (halt) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign core_clear    = (state_q == S_CLEAR);
    assign pc_load       = (state_q == S_CLEAR);
    assign pc_load_value = base_q;
    assign pc_en         = (state_q == S_RUN) && !halt;
    assign busy          = (state_q == S_CLEAR) || (state_q == S_HOLD) || (state_q == S_RUN);
    assign done          = (state_q == S_DONE);
    assign cycle_count   = cnt_q;
    assign timeout       = timeout_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer with a scoreboard of per-run expectations.
module tb_program_sequencer;
    localparam int unsigned PC_W  = 32;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [1:0]       prog_sel;
    logic             halt;
    logic             pc_en;
    logic             pc_load;
    logic [PC_W-1:0]  pc_load_value;
    logic             core_clear;
    logic             done;
    logic             busy;
    logic [CNT_W-1:0] cycle_count;
    logic             timeout;

    int checks = 0;
    int errors = 0;
    int en_cnt;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    program_sequencer #(
        .PC_W(PC_W), .CNT_W(CNT_W),
        .PROG0_BASE(0), .PROG1_BASE(256), .PROG2_BASE(512), .PROG3_BASE(768),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel), .halt(halt),
        .pc_en(pc_en), .pc_load(pc_load), .pc_load_value(pc_load_value),
        .core_clear(core_clear), .done(done), .busy(busy),
        .cycle_count(cycle_count), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty: got %0h want none", obs);
        end else begin
            e = sb.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; start = 1'b1; prog_sel = 2'd0; halt = 1'b0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pc_en", 32'(pc_en), 32'd0);
        chk("rst_pc_load", 32'(pc_load), 32'd0);
        chk("rst_core_clear", 32'(core_clear), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_count", 32'(cycle_count), 32'd0);
        chk("rst_base", pc_load_value, 32'd0);

        // release reset with start held high: counts as a start rise
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("rel_core_clear", 32'(core_clear), 32'd1);
        chk("rel_pc_load", 32'(pc_load), 32'd1);
        chk("rel_busy", 32'(busy), 32'd1);
        tick();
        chk("hold_core_clear", 32'(core_clear), 32'd0);
        chk("hold_pc_load", 32'(pc_load), 32'd0);
        chk("hold_busy", 32'(busy), 32'd1);
        chk("hold_pc_en", 32'(pc_en), 32'd0);
        tick();
        chk("hold2_busy", 32'(busy), 32'd1);
        halt = 1'b1;
        #1;
        chk("hold_halt_ignored", 32'(pc_en), 32'd0);
        halt = 1'b0;
        start = 1'b0;
        tick();
        chk("run1_busy", 32'(busy), 32'd1);
        halt = 1'b1;
        #1;
        chk("run1_halt_pc_en", 32'(pc_en), 32'd0);
        tick();
        halt = 1'b0;
        chk("short_done", 32'(done), 32'd1);
        chk("short_count", 32'(cycle_count), 32'd1);
        chk("short_busy", 32'(busy), 32'd0);

        // prog 2, halt on the 10th RUN cycle
        prog_sel = 2'd2;
        start = 1'b1;
        push("p2_base", 32'd512);
        push("p2_count", 32'd10);
        push("p2_en_cycles", 32'd9);
        tick();
        chk("p2_clear_done", 32'(done), 32'd0);
        chk("p2_clear_cc", 32'(core_clear), 32'd1);
        pop_chk(pc_load_value);
        start = 1'b0;
        tick();
        tick();
        en_cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            halt = (i == 10);
            #1;
            if (pc_en) en_cnt++;
            if (i == 10) chk("p2_halt_pc_en", 32'(pc_en), 32'd0);
            tick();
        end
        halt = 1'b0;
        chk("p2_done", 32'(done), 32'd1);
        pop_chk(cycle_count);
        pop_chk(32'(en_cnt));
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("p2_done_held", 32'(done), 32'd1);
            chk("p2_count_held", 32'(cycle_count), 32'd10);
        end

        // restart from DONE with prog 1
        prog_sel = 2'd1;
        start = 1'b1;
        push("p1_base", 32'd256);
        tick();
        chk("p1_done_fell", 32'(done), 32'd0);
        chk("p1_pc_load", 32'(pc_load), 32'd1);
        pop_chk(pc_load_value);
        start = 1'b0;
        tick();
        chk("p1_count_clr", 32'(cycle_count), 32'd0);
        tick();
        for (int i = 1; i <= 4; i++) tick();
        chk("p1_count_run5", 32'(cycle_count), 32'd4);

        // start rise and halt together on RUN cycle 5: restart wins
        halt = 1'b1;
        prog_sel = 2'd3;
        start = 1'b1;
        push("abort_base", 32'd768);
        tick();
        halt = 1'b0;
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_cc", 32'(core_clear), 32'd1);
        chk("abort_busy", 32'(busy), 32'd1);
        pop_chk(pc_load_value);
        start = 1'b0;
        tick();
        chk("abort_count_clr", 32'(cycle_count), 32'd0);
        tick();
        tick();
        tick();
        chk("pre_rst_pc_en", 32'(pc_en), 32'd1);
        chk("pre_rst_count", 32'(cycle_count), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        chk("async_pc_en", 32'(pc_en), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_count", 32'(cycle_count), 32'd0);
        chk("async_base", pc_load_value, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // long run without halt: watchdog build stops at 50
        prog_sel = 2'd0;
        start = 1'b1;
        tick();
        chk("wd_clear", 32'(core_clear), 32'd1);
        start = 1'b0;
        tick();
        tick();
        for (int i = 1; i < 100; i++) tick();
`ifdef PROGRAM_SEQUENCER_WATCHDOG_EN
        chk("wd_done", 32'(done), 32'd1);
        chk("wd_timeout", 32'(timeout), 32'd1);
        chk("wd_count", 32'(cycle_count), 32'd50);
        chk("wd_busy", 32'(busy), 32'd0);
`else
        chk("nowd_busy", 32'(busy), 32'd1);
        chk("nowd_timeout", 32'(timeout), 32'd0);
        chk("nowd_count", 32'(cycle_count), 32'd99);
        chk("nowd_pc_en", 32'(pc_en), 32'd1);
`endif
        start = 1'b1;
        tick();
        chk("re_clear_cc", 32'(core_clear), 32'd1);
        tick();
        chk("re_timeout_clr", 32'(timeout), 32'd0);
        chk("re_count_clr", 32'(cycle_count), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "bench time limit");
    end
endmodule
